seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
//   Each digit takes a 5-bit symbol code: 0-15 hex, 16 blank, 17 '-', 18 P, 19 c, 20 r, 21 t, 22 o, 23 i, 24-31 blank.
//   Adds digit scanning, anti-ghost blanking, double-buffered update, leading-zero suppression and per-digit blink.
//   Sits between the SAP-1 output/status logic and the board display pins.
// PARAMETERS
//   NUM_DIGITS   4      digits scanned, range 2..8; digit 0 is the least significant (rightmost)
//   SCAN_DIV     50000  clocks per digit slot, at least BLANK_CYC+2
//   BLANK_CYC    500    clocks at the start of each slot with all anodes off
//   BLINK_FRAMES 64     full scan frames per blink half-period, at least 1
// PORTS
//   clk        in   1             system clock, rising edge
//   rst_n      in   1             asynchronous reset, active low
//   codes      in   5*NUM_DIGITS  symbol codes; digit k is codes[5k+4:5k]
//   dp         in   NUM_DIGITS    decimal point request per digit, active high
//   load       in   1             1-clk strobe: capture codes and dp into the shadow buffer
//   lz_en      in   1             leading-zero suppression enable, sampled live
//   blink_mask in   NUM_DIGITS    digits that blink, sampled live
//   seg_n      out  7             segments {g,f,e,d,c,b,a}, active low
//   dp_n       out  1             decimal point, active low
//   an_n       out  NUM_DIGITS    digit anodes, one-hot-low or all high
//   frame_tick out  1             1-clk pulse when the digit index wraps
// BEHAVIOUR
//   Reset (async assert, sync release) sets:
//     seg_n=7'h7F, dp_n=1, an_n=all 1s, frame_tick=0;
//     prescaler=0, digit index=0, blink phase=on, blink counter=0;
//     shadow and active codes=16 (blank), shadow and active dp=0.
//   Prescaler counts 0..SCAN_DIV-1 and wraps to 0.
//   At prescaler==SCAN_DIV-1 the index advances.
//   When the index is NUM_DIGITS-1 it wraps to 0, and that cycle is the frame wrap.
//   frame_tick is registered: it is high for the cycle after the frame wrap.
//   load=1 copies codes and dp into shadow.
//   At each frame wrap, shadow is copied into active.
//   If load and frame wrap occur in the same cycle, active takes the live codes/dp inputs.
//   A display frame therefore never mixes old and new values.
//   Symbol selection for digit k (effective symbol):
//     LZ: k is suppressed if lz_en=1, k!=0, and active codes are 0 for k and every higher digit.
//       A suppressed digit shows 16 and its dp is forced off.
//     Blink: the blink counter counts frame wraps.
//       At BLINK_FRAMES-1 it resets to 0 and the phase toggles.
//       In the off phase, digits with blink_mask[k]=1 show 16 and their dp is off.
//   Anode output:
//     While prescaler<BLANK_CYC, an_n is all 1s.
//     Otherwise an_n[index]=0 and all other bits are 1.
//   seg_n and dp_n are registered.
//     They update 1 clk after the index or state change and are coincident with an_n, which is also registered.
//     While an_n is all 1s, seg_n=7'h7F and dp_n=1.
//   Segment encodings:
//     0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E
//     16=7F, 17=3F, 18=0C, 19=27, 20=2F, 21=07, 22=23, 23=7B, 24-31=7F
//   Mid-operation reset immediately forces all outputs dark.
//   After reset release, scanning restarts at digit 0 with blank content until the first load plus frame wrap.
// TESTING (bench: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2)
//   1. Reset, then run 40 clks with no load -> seg_n=7F, dp_n=1; an_n cycles 1110, 1101, 1011, 0111, each low for 3 clks after 1 dark clk; frame_tick pulses every 16 clks.
//   2. load codes={3,2,1,0}, dp=4'b0010 mid-frame -> unchanged until the next frame_tick; then digit0 seg=40, digit1 seg=79 with dp_n=0, digit2=24, digit3=30.
//   3. codes={0,0,5,0}, lz_en=1 -> digits 3 and 2 seg=7F, digit1=12, digit0=40; with lz_en=0, digits 3 and 2 show 40.
//   4. blink_mask=4'b0001, codes={8,8,8,8} -> digit0 alternates 00 / 7F every 2 frames; digits 1-3 stay 00.
//   5. load asserted on the frame-wrap cycle with codes={17,17,17,17} -> the very next frame shows 3F on all digits.
//   6. Assert rst_n=0 while digit2 is lit -> an_n=1111 and seg_n=7F within the same cycle; after release, scan restarts at digit0 showing blank.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//   Upstream content bus for the 7-segment scan driver. The SAP-1 output and
//   status logic drives it through the master modport, and the driver reads
//   it through the slave modport.
//   codes      5*NUM_DIGITS  symbol codes, digit k is codes[5k+4:5k]
//   dp         NUM_DIGITS    decimal point request per digit, active high
//   load       1             one-clock strobe that captures codes and dp
//   lz_en      1             leading-zero suppression enable, used live
//   blink_mask NUM_DIGITS    digits that blink, used live
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [5*NUM_DIGITS-1:0] codes;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   blink_mask;

  modport master (output codes, dp, load, lz_en, blink_mask);
  modport slave  (input  codes, dp, load, lz_en, blink_mask);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
//   Scans one digit per SCAN_DIV clocks, keeps all anodes off for the first
//   BLANK_CYC clocks of every slot, and double-buffers the content so that
//   a scan frame never mixes old and new values. Leading-zero suppression
//   and per-digit blink are applied on the active copy at display time.
//   Symbol codes: 0-15 hex, 16 blank, 17 '-', 18 P, 19 c, 20 r, 21 t,
//   22 o, 23 i, 24-31 blank.
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   bus        in   content bus (slave): codes, dp, load, lz_en, blink_mask
//   seg_n      out  segments {g,f,e,d,c,b,a}, active low
//   dp_n       out  decimal point, active low
//   an_n       out  digit anodes, one-hot-low or all high
//   frame_tick out  one-clock pulse the cycle after the digit index wraps
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_driver_if.slave     bus,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [4:0] SYM_BLANK = 5'd16;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  logic [NUM_DIGITS-1:0][4:0] shadow_codes;
  logic [NUM_DIGITS-1:0][4:0] active_codes;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [NUM_DIGITS-1:0]      active_dp;

  logic                  slot_end;
  logic                  frame_wrap;
  logic                  dark;
  logic [NUM_DIGITS-1:0] hide;
  logic                  zero_run;
  logic [4:0]            sel_code;
  logic                  sel_dp;
  logic [NUM_DIGITS-1:0] an_next;

  // Segment patterns, active low, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [4:0] sym);
    logic [6:0] pat;
    case (sym)
      5'd0:    pat = 7'h40;
      5'd1:    pat = 7'h79;
      5'd2:    pat = 7'h24;
      5'd3:    pat = 7'h30;
      5'd4:    pat = 7'h19;
      5'd5:    pat = 7'h12;
      5'd6:    pat = 7'h02;
      5'd7:    pat = 7'h78;
      5'd8:    pat = 7'h00;
      5'd9:    pat = 7'h18;
      5'd10:   pat = 7'h08;
      5'd11:   pat = 7'h03;
      5'd12:   pat = 7'h46;
      5'd13:   pat = 7'h21;
      5'd14:   pat = 7'h06;
      5'd15:   pat = 7'h0E;
      5'd17:   pat = 7'h3F;
      5'd18:   pat = 7'h0C;
      5'd19:   pat = 7'h27;
      5'd20:   pat = 7'h2F;
      5'd21:   pat = 7'h07;
      5'd22:   pat = 7'h23;
      5'd23:   pat = 7'h7B;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  assign slot_end   = (presc == PW'(SCAN_DIV - 1));
  assign frame_wrap = slot_end && (idx == IW'(NUM_DIGITS - 1));
  assign dark       = (presc < PW'(BLANK_CYC));

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      if (slot_end) begin
        presc <= '0;
        if (frame_wrap) begin
          idx <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Double buffer. A load coinciding with the frame wrap bypasses the
  // shadow so the very next frame already shows the new content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_codes <= {NUM_DIGITS{SYM_BLANK}};
      active_codes <= {NUM_DIGITS{SYM_BLANK}};
      shadow_dp    <= '0;
      active_dp    <= '0;
    end else begin
      if (bus.load) begin
        shadow_codes <= bus.codes;
        shadow_dp    <= bus.dp;
      end
      if (frame_wrap) begin
        if (bus.load) begin
          active_codes <= bus.codes;
          active_dp    <= bus.dp;
        end else begin
          active_codes <= shadow_codes;
          active_dp    <= shadow_dp;
        end
      end
    end
  end

  // Blink phase flips every BLINK_FRAMES frame wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_wrap) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Walking down from the top digit, zero_run stays set only while every
  // digit seen so far is a literal 0; digit 0 is never suppressed.
  always_comb begin
    zero_run = 1'b1;
    hide     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (active_codes[k] == 5'd0);
      if ((bus.lz_en && (k != 0) && zero_run) ||
          (!blink_on && bus.blink_mask[k])) begin
        hide[k] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_code     = hide[idx] ? SYM_BLANK : active_codes[idx];
    sel_dp       = !hide[idx] && active_dp[idx];
    an_next      = '1;
    an_next[idx] = 1'b0;
  end

  // Display pins are registered together so anodes, segments and dp
  // always change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= '1;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (dark) begin
        an_n  <= '1;
        seg_n <= 7'h7F;
        dp_n  <= 1'b1;
      end else begin
        an_n  <= an_next;
        seg_n <= seg_decode(sel_code);
        dp_n  <= ~sel_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Self-checking bench for seg7_scan_driver with a small scan geometry.
//   A reference model derives the expected display from a cycle count since
//   reset plus a frame count, and the scenario tasks add direct checks
//   against the documented segment patterns.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int BF    = 2;
  localparam int FRAME = SD * ND;

  localparam logic [6:0] SEG_TAB [32] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
    7'h7F, 7'h3F, 7'h0C, 7'h27, 7'h2F, 7'h07, 7'h23, 7'h7B,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [ND-1:0] an_n;
  logic          frame_tick;

  int checks = 0;
  int fails  = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: m_cnt counts clocks since reset release, m_frames
  // counts completed frames. Outputs lag the counted position by one clock.
  int unsigned   m_cnt;
  int            m_frames;
  logic [4:0]    m_shadow [ND];
  logic [4:0]    m_active [ND];
  logic [ND-1:0] m_sdp, m_adp;
  logic [6:0]    exp_seg;
  logic          exp_dp;
  logic [ND-1:0] exp_an;
  logic          exp_tick;

  int            m_slot, m_digit;
  logic          m_wrap, m_blink_off, m_hidden;
  logic [6:0]    m_next_seg;
  logic          m_next_dp;
  logic [ND-1:0] m_next_an;

  always_comb begin
    m_slot      = int'(m_cnt % SD);
    m_digit     = int'((m_cnt / SD) % ND);
    m_wrap      = ((m_cnt % FRAME) == FRAME - 1);
    m_blink_off = ((m_frames / BF) % 2) == 1;
    m_hidden    = 1'b0;
    if (bus.lz_en && m_digit != 0) begin
      m_hidden = 1'b1;
      for (int j = m_digit; j < ND; j++) if (m_active[j] != 5'd0) m_hidden = 1'b0;
    end
    if (m_blink_off && bus.blink_mask[m_digit]) m_hidden = 1'b1;
    m_next_seg = m_hidden ? 7'h7F : SEG_TAB[m_active[m_digit]];
    m_next_dp  = m_hidden ? 1'b1 : !m_adp[m_digit];
    m_next_an  = '1;
    if (m_slot < BC) begin
      m_next_seg = 7'h7F;
      m_next_dp  = 1'b1;
    end else begin
      m_next_an[m_digit] = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 0;
      m_frames <= 0;
      for (int k = 0; k < ND; k++) begin
        m_shadow[k] <= 5'd16;
        m_active[k] <= 5'd16;
      end
      m_sdp    <= '0;
      m_adp    <= '0;
      exp_seg  <= 7'h7F;
      exp_dp   <= 1'b1;
      exp_an   <= '1;
      exp_tick <= 1'b0;
    end else begin
      exp_seg  <= m_next_seg;
      exp_dp   <= m_next_dp;
      exp_an   <= m_next_an;
      exp_tick <= m_wrap;
      if (bus.load) begin
        for (int k = 0; k < ND; k++) m_shadow[k] <= bus.codes[5*k +: 5];
        m_sdp <= bus.dp;
      end
      if (m_wrap) begin
        m_frames <= m_frames + 1;
        for (int k = 0; k < ND; k++) m_active[k] <= bus.load ? bus.codes[5*k +: 5] : m_shadow[k];
        m_adp <= bus.load ? bus.dp : m_sdp;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic test_reset;
    bus.codes = '0; bus.dp = '0; bus.load = 1'b0; bus.lz_en = 1'b0; bus.blink_mask = '0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_state: got an_n=%b seg_n=%h dp_n=%b tick=%b, want an_n=1111 seg_n=7f dp_n=1 tick=0", an_n, seg_n, dp_n, frame_tick);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan;
    int last_tick = -1;
    int ticks = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp || frame_tick !== exp_tick) begin
        fails++;
        $display("[TB] FAIL idle_scan cyc %0d: got an_n=%b seg_n=%h dp_n=%b tick=%b, want an_n=%b seg_n=%h dp_n=%b tick=%b", i, an_n, seg_n, dp_n, frame_tick, exp_an, exp_seg, exp_dp, exp_tick);
      end
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          checks++;
          if (i - last_tick != FRAME) begin
            fails++;
            $display("[TB] FAIL tick_period: got %0d clks, want %0d", i - last_tick, FRAME);
          end
        end
        last_tick = i;
        ticks++;
      end
    end
    checks++;
    if (ticks != 2) begin
      fails++;
      $display("[TB] FAIL tick_count: got %0d, want 2", ticks);
    end
  endtask

  task automatic test_load;
    logic [6:0] want [ND];
    logic       want_dpn [ND];
    bit after = 0;
    int post = 0;
    int d;
    want = '{7'h40, 7'h79, 7'h24, 7'h30};
    want_dpn = '{1'b1, 1'b0, 1'b1, 1'b1};
    bus.codes = {5'd3, 5'd2, 5'd1, 5'd0};
    bus.dp = 4'b0010;
    bus.load = 1'b1;
    for (int i = 0; i < 40 && post < FRAME; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp || frame_tick !== exp_tick) begin
        fails++;
        $display("[TB] FAIL load_model cyc %0d: got an_n=%b seg_n=%h dp_n=%b tick=%b, want an_n=%b seg_n=%h dp_n=%b tick=%b", i, an_n, seg_n, dp_n, frame_tick, exp_an, exp_seg, exp_dp, exp_tick);
      end
      if (!after) begin
        checks++;
        if (seg_n !== 7'h7F || dp_n !== 1'b1) begin
          fails++;
          $display("[TB] FAIL load_early: got seg_n=%h dp_n=%b, want seg_n=7f dp_n=1", seg_n, dp_n);
        end
        if (frame_tick === 1'b1) after = 1;
      end else begin
        post++;
        d = -1;
        for (int j = 0; j < ND; j++) if (an_n[j] === 1'b0) d = j;
        checks++;
        if (d >= 0 && (seg_n !== want[d] || dp_n !== want_dpn[d])) begin
          fails++;
          $display("[TB] FAIL load_digit%0d: got seg_n=%h dp_n=%b, want seg_n=%h dp_n=%b", d, seg_n, dp_n, want[d], want_dpn[d]);
        end else if (d < 0 && (seg_n !== 7'h7F || dp_n !== 1'b1)) begin
          fails++;
          $display("[TB] FAIL load_dark: got seg_n=%h dp_n=%b, want seg_n=7f dp_n=1", seg_n, dp_n);
        end
      end
    end
    checks++;
    if (post < FRAME) begin
      fails++;
      $display("[TB] FAIL load_timeout: got %0d post-tick clks, want %0d", post, FRAME);
    end
  endtask

  task automatic test_lz;
    logic [6:0] want_on [ND];
    logic [6:0] want_off [ND];
    int ph = 0;
    int post = 0;
    int d;
    want_on  = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    want_off = '{7'h40, 7'h12, 7'h40, 7'h40};
    bus.codes = {5'd0, 5'd0, 5'd5, 5'd0};
    bus.dp = '0;
    bus.lz_en = 1'b1;
    bus.load = 1'b1;
    for (int i = 0; i < 80 && ph < 3; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp || frame_tick !== exp_tick) begin
        fails++;
        $display("[TB] FAIL lz_model cyc %0d: got an_n=%b seg_n=%h dp_n=%b tick=%b, want an_n=%b seg_n=%h dp_n=%b tick=%b", i, an_n, seg_n, dp_n, frame_tick, exp_an, exp_seg, exp_dp, exp_tick);
      end
      if (ph == 0) begin
        if (frame_tick === 1'b1) ph = 1;
      end else begin
        d = -1;
        for (int j = 0; j < ND; j++) if (an_n[j] === 1'b0) d = j;
        if (d >= 0) begin
          checks++;
          if (seg_n !== (ph == 1 ? want_on[d] : want_off[d])) begin
            fails++;
            $display("[TB] FAIL lz_digit%0d lz_en=%0d: got seg_n=%h, want %h", d, ph == 1, seg_n, ph == 1 ? want_on[d] : want_off[d]);
          end
        end
        post++;
        if (post == FRAME) begin
          post = 0;
          ph++;
          bus.lz_en = 1'b0;
        end
      end
    end
    checks++;
    if (ph < 3) begin
      fails++;
      $display("[TB] FAIL lz_timeout: got phase %0d, want 3", ph);
    end
  endtask

  task automatic test_blink;
    logic [6:0] d0_val [6];
    int f = -1;
    int d;
    bus.codes = {5'd8, 5'd8, 5'd8, 5'd8};
    bus.dp = '0;
    bus.lz_en = 1'b0;
    bus.blink_mask = 4'b0001;
    bus.load = 1'b1;
    for (int k = 0; k < 6; k++) d0_val[k] = 7'h55;
    for (int i = 0; i < 130 && f < 6; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp || frame_tick !== exp_tick) begin
        fails++;
        $display("[TB] FAIL blink_model cyc %0d: got an_n=%b seg_n=%h dp_n=%b tick=%b, want an_n=%b seg_n=%h dp_n=%b tick=%b", i, an_n, seg_n, dp_n, frame_tick, exp_an, exp_seg, exp_dp, exp_tick);
      end
      if (frame_tick === 1'b1) f++;
      else if (f >= 0 && f < 6) begin
        d = -1;
        for (int j = 0; j < ND; j++) if (an_n[j] === 1'b0) d = j;
        if (d == 0) d0_val[f] = seg_n;
        else if (d > 0) begin
          checks++;
          if (seg_n !== 7'h00) begin
            fails++;
            $display("[TB] FAIL blink_steady digit%0d: got seg_n=%h, want 00", d, seg_n);
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!((d0_val[k] == 7'h00 && d0_val[k+2] == 7'h7F) || (d0_val[k] == 7'h7F && d0_val[k+2] == 7'h00))) begin
        fails++;
        $display("[TB] FAIL blink_alternate frame %0d: got %h then %h, want opposite of 00/7f two frames apart", k, d0_val[k], d0_val[k+2]);
      end
    end
    bus.blink_mask = '0;
  endtask

  task automatic test_load_on_wrap;
    int stage = 0;
    int post = 0;
    int d;
    for (int i = 0; i < 80 && stage < 4; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp || frame_tick !== exp_tick) begin
        fails++;
        $display("[TB] FAIL wrap_model cyc %0d: got an_n=%b seg_n=%h dp_n=%b tick=%b, want an_n=%b seg_n=%h dp_n=%b tick=%b", i, an_n, seg_n, dp_n, frame_tick, exp_an, exp_seg, exp_dp, exp_tick);
      end
      if (stage == 0 && (m_cnt % FRAME) == 5) begin
        bus.codes = {5'd9, 5'd9, 5'd9, 5'd9};
        bus.load = 1'b1;
        stage = 1;
      end else if (stage == 1 && (m_cnt % FRAME) == FRAME - 1) begin
        bus.codes = {5'd17, 5'd17, 5'd17, 5'd17};
        bus.load = 1'b1;
        stage = 2;
      end else if (stage == 2) begin
        stage = 3;
      end else if (stage == 3) begin
        d = -1;
        for (int j = 0; j < ND; j++) if (an_n[j] === 1'b0) d = j;
        if (d >= 0) begin
          checks++;
          if (seg_n !== 7'h3F) begin
            fails++;
            $display("[TB] FAIL wrap_load digit%0d: got seg_n=%h, want 3f", d, seg_n);
          end
        end
        post++;
        if (post == FRAME) stage = 4;
      end
    end
    checks++;
    if (stage < 4) begin
      fails++;
      $display("[TB] FAIL wrap_timeout: got stage %0d, want 4", stage);
    end
  endtask

  task automatic test_random;
    int gap;
    for (int n = 0; n < 25; n++) begin
      gap = $urandom_range(0, 20);
      for (int i = 0; i <= gap; i++) begin
        @(negedge clk);
        bus.load = 1'b0;
        checks++;
        if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp || frame_tick !== exp_tick) begin
          fails++;
          $display("[TB] FAIL random_model iter %0d: got an_n=%b seg_n=%h dp_n=%b tick=%b, want an_n=%b seg_n=%h dp_n=%b tick=%b", n, an_n, seg_n, dp_n, frame_tick, exp_an, exp_seg, exp_dp, exp_tick);
        end
      end
      for (int k = 0; k < ND; k++) begin
        bus.codes[5*k +: 5] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      end
      bus.dp = 4'($urandom);
      bus.lz_en = 1'($urandom);
      bus.blink_mask = 4'($urandom);
      bus.load = 1'b1;
    end
    @(negedge clk);
    bus.load = 1'b0;
    bus.blink_mask = '0;
  endtask

  task automatic test_reset_mid_scan;
    bit found = 0;
    bit first_lit = 1;
    int d;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an_n === 4'b1011) found = 1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL midreset_find: got an_n=%b, want 1011 within 40 clks", an_n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_dark: got an_n=%b seg_n=%h dp_n=%b tick=%b, want an_n=1111 seg_n=7f dp_n=1 tick=0", an_n, seg_n, dp_n, frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp || frame_tick !== exp_tick) begin
        fails++;
        $display("[TB] FAIL midreset_model cyc %0d: got an_n=%b seg_n=%h dp_n=%b tick=%b, want an_n=%b seg_n=%h dp_n=%b tick=%b", i, an_n, seg_n, dp_n, frame_tick, exp_an, exp_seg, exp_dp, exp_tick);
      end
      d = -1;
      for (int j = 0; j < ND; j++) if (an_n[j] === 1'b0) d = j;
      if (d >= 0) begin
        checks++;
        if ((first_lit && d != 0) || seg_n !== 7'h7F) begin
          fails++;
          $display("[TB] FAIL midreset_restart: got digit %0d seg_n=%h, want digit 0 first and seg_n=7f", d, seg_n);
        end
        first_lit = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load();
    test_lz();
    test_blink();
    test_load_on_wrap();
    test_random();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
